// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single regfile write port, with a pending scoreboard for read hazards.
// Optional macro REGFILE_WB_ARBITER_FWD_EN adds fwd1/fwd2 and drops the in-flight write term from hazard.
module regfile_wb_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [ADDR_W-1:0]        raddr1,
  input  logic [ADDR_W-1:0]        raddr2,
  output logic                     hazard,
  output logic [(2**ADDR_W)-1:0]   pending,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata
`ifdef REGFILE_WB_ARBITER_FWD_EN
  ,
  output logic                     fwd1,
  output logic                     fwd2
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG  = 2 ** ADDR_W;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  win;
  logic              found;
  logic [NREQ-1:0]   grant;
  logic              transfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              real_write;
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_next;
  logic              pend_hit;
  logic              we_hit1;
  logic              we_hit2;

  // Scan upward from the pointer with wrap; the first valid requester wins.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
      idx = (idx == PTR_W'(NREQ - 1)) ? '0 : idx + PTR_W'(1);
    end
  end

  assign req_ready = grant;
  assign transfer  = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to register 0 complete the handshake but never reach the regfile or scoreboard.
  assign real_write = transfer && (sel_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= real_write;
      if (real_write) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  // Clear first, then set, so a reservation landing with a writeback to the same register wins.
  always_comb begin
    pending_next = pending_q;
    if (real_write) begin
      pending_next[sel_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      pending_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

  assign pending = pending_q;

  assign pend_hit = ((raddr1 != '0) && pending_q[raddr1]) ||
                    ((raddr2 != '0) && pending_q[raddr2]);
  assign we_hit1  = rf_we && (rf_waddr != '0) && (rf_waddr == raddr1);
  assign we_hit2  = rf_we && (rf_waddr != '0) && (rf_waddr == raddr2);

`ifdef REGFILE_WB_ARBITER_FWD_EN
  assign fwd1   = we_hit1;
  assign fwd2   = we_hit2;
  assign hazard = pend_hit;
`else
  // The registered write is not yet visible to regfile reads, so it must stall too.
  assign hazard = pend_hit || we_hit1 || we_hit2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: a two-requester instance plus a three-requester instance.
// Covers both builds, with and without REGFILE_WB_ARBITER_FWD_EN.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;

  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        hazard;
  logic [31:0] pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [2:0]  req_valid3;
  logic [14:0] req_addr3;
  logic [95:0] req_data3;
  logic [2:0]  req_ready3;
  logic        hazard3;
  logic [31:0] pending3;
  logic        rf_we3;
  logic [4:0]  rf_waddr3;
  logic [31:0] rf_wdata3;

`ifdef REGFILE_WB_ARBITER_FWD_EN
  logic fwd1, fwd2, fwd1_3, fwd2_3;
`endif

  int checks;
  int errors;

  regfile_wb_arbiter #(.NREQ(2), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .hazard(hazard), .pending(pending),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef REGFILE_WB_ARBITER_FWD_EN
    , .fwd1(fwd1), .fwd2(fwd2)
`endif
  );

  regfile_wb_arbiter #(.NREQ(3), .DATA_W(32), .ADDR_W(5)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_addr(req_addr3), .req_data(req_data3), .req_ready(req_ready3),
    .rsv_valid(1'b0), .rsv_addr(5'd0), .raddr1(5'd0), .raddr2(5'd0),
    .hazard(hazard3), .pending(pending3),
    .rf_we(rf_we3), .rf_waddr(rf_waddr3), .rf_wdata(rf_wdata3)
`ifdef REGFILE_WB_ARBITER_FWD_EN
    , .fwd1(fwd1_3), .fwd2(fwd2_3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both requesters of the two-port instance.
  task automatic applyStimulus(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    rsv_valid  = 1'b0;
    rsv_addr   = '0;
    raddr1     = '0;
    raddr2     = '0;
    req_valid3 = '0;
    req_addr3  = '0;
    req_data3  = '0;

    #2;
    checkOutput("reset_we", rf_we, 0);
    checkOutput("reset_pending", pending, 0);
    checkOutput("reset_hazard", hazard, 0);
    checkOutput("reset_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("idle_we", rf_we, 0);
    checkOutput("idle_ready", req_ready, 0);

    // Alternating grants with both requesters always valid.
    applyStimulus(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
    checkOutput("alt_ready0", req_ready, 2'b01);
    checkOutput("alt_we_before", rf_we, 0);
    tick();
    checkOutput("alt_ready1", req_ready, 2'b10);
    checkOutput("alt_we1", rf_we, 1);
    checkOutput("alt_waddr1", rf_waddr, 3);
    checkOutput("alt_wdata1", rf_wdata, 32'h11);
    tick();
    checkOutput("alt_ready2", req_ready, 2'b01);
    checkOutput("alt_waddr2", rf_waddr, 4);
    checkOutput("alt_wdata2", rf_wdata, 32'h22);
    tick();
    checkOutput("alt_ready3", req_ready, 2'b10);
    checkOutput("alt_waddr3", rf_waddr, 3);
    tick();
    checkOutput("alt_we4", rf_we, 1);
    checkOutput("alt_waddr4", rf_waddr, 4);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    checkOutput("alt_ready_none", req_ready, 0);
    tick();
    checkOutput("alt_we_off", rf_we, 0);
    checkOutput("alt_waddr_hold", rf_waddr, 4);
    checkOutput("alt_wdata_hold", rf_wdata, 32'h22);

    // Reservation of r7 followed by its writeback from requester 1.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    raddr1    = 5'd7;
    #1;
    checkOutput("rsv_hazard_early", hazard, 0);
    tick();
    rsv_valid = 1'b0;
    #1;
    checkOutput("rsv_hazard", hazard, 1);
    checkOutput("rsv_pending", pending, 32'h80);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd7, 32'hDEAD);
    checkOutput("wb7_ready", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    checkOutput("wb7_pending", pending, 0);
    checkOutput("wb7_we", rf_we, 1);
    checkOutput("wb7_waddr", rf_waddr, 7);
    checkOutput("wb7_wdata", rf_wdata, 32'hDEAD);
`ifdef REGFILE_WB_ARBITER_FWD_EN
    checkOutput("wb7_hazard", hazard, 0);
    checkOutput("wb7_fwd1", fwd1, 1);
    checkOutput("wb7_fwd2", fwd2, 0);
`else
    checkOutput("wb7_hazard", hazard, 1);
`endif
    tick();
    checkOutput("wb7_hazard_after", hazard, 0);
    checkOutput("wb7_we_after", rf_we, 0);
    raddr1 = 5'd0;

    // Reservation and writeback to r5 in the same cycle: the reservation survives.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    applyStimulus(2'b01, 5'd5, 32'h55, 5'd0, 32'h0);
    checkOutput("same_ready", req_ready, 2'b01);
    tick();
    rsv_valid = 1'b0;
    raddr2    = 5'd5;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    checkOutput("same_pending", pending, 32'h20);
    checkOutput("same_we", rf_we, 1);
    checkOutput("same_waddr", rf_waddr, 5);
    checkOutput("same_hazard", hazard, 1);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd5, 32'h66);
    checkOutput("r5_ready", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    checkOutput("r5_pending", pending, 0);
    checkOutput("r5_wdata", rf_wdata, 32'h66);
    tick();
    checkOutput("r5_hazard_after", hazard, 0);
    raddr2 = 5'd0;

    // Write to r0: handshake completes, pointer advances, nothing is written.
    applyStimulus(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0);
    checkOutput("zero_ready", req_ready, 2'b01);
    tick();
    applyStimulus(2'b11, 5'd0, 32'hFFFF, 5'd4, 32'h22);
    checkOutput("zero_we", rf_we, 0);
    checkOutput("zero_pending", pending, 0);
    checkOutput("zero_hazard", hazard, 0);
    checkOutput("zero_ptr_adv", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    checkOutput("zero_next_waddr", rf_waddr, 4);

    // Reset asserted while a write is registered and r9 is reserved.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    tick();
    rsv_valid = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    checkOutput("mid_we", rf_we, 1);
    checkOutput("mid_pending", pending, 32'h200);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we", rf_we, 0);
    checkOutput("mid_rst_waddr", rf_waddr, 0);
    checkOutput("mid_rst_pending", pending, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    checkOutput("mid_rst_ptr", req_ready, 2'b01);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // Three-requester instance: wrap from requester 2 back to requester 0.
    req_valid3 = 3'b100;
    req_addr3  = {5'd6, 5'd0, 5'd2};
    req_data3  = {32'h66, 32'h0, 32'h2};
    #1;
    checkOutput("n3_ready_r2", req_ready3, 3'b100);
    tick();
    req_valid3 = 3'b101;
    #1;
    checkOutput("n3_waddr_r2", rf_waddr3, 6);
    checkOutput("n3_ready_wrap", req_ready3, 3'b001);
    tick();
    checkOutput("n3_waddr_r0", rf_waddr3, 2);
    checkOutput("n3_wdata_r0", rf_wdata3, 32'h2);
    checkOutput("n3_ready_then_r2", req_ready3, 3'b100);
    req_valid3 = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
